// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the run/step/breakpoint sequencer: FSM states and
// run-rate select codes.
package cpu_step_ctrl_pkg;

   localparam logic [1:0] ST_HALT = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_BRK  = 2'd3;

   localparam logic [1:0] SPD_EVERY = 2'b00;
   localparam logic [1:0] SPD_2P8   = 2'b01;
   localparam logic [1:0] SPD_2P16  = 2'b10;
   localparam logic [1:0] SPD_MAX   = 2'b11;

endpackage

// File: rtl/cpu_step_ctrl_run_tick_gen.sv
// Run-rate divider: counts while enabled and pulses tick on the terminal count
// chosen by speed_sel, then wraps to zero.
module run_tick_gen
   import cpu_step_ctrl_pkg::*;
#(
   parameter int unsigned RUN_DIV_W = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [1:0] speed_sel,
   output logic       tick
);

   logic [RUN_DIV_W-1:0] div;
   logic [RUN_DIV_W-1:0] term;

   always_comb begin
      term = '0;
      case (speed_sel)
         SPD_EVERY: term = '0;
         SPD_2P8:   term[7:0] = '1;
         SPD_2P16:  term[15:0] = '1;
         SPD_MAX:   term = '1;
      endcase
   end

   // Held clear outside RUN so every entry to RUN starts from zero.
   assign tick = !clr && (div == term);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= '0;
      end else if (clr || tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer issuing one-cycle CPU clock-enables, with a
// step counter and sticky breakpoint flag for the board display.
module cpu_step_ctrl
   import cpu_step_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BRK_W     = 8,
   parameter int unsigned RUN_DIV_W = 24,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_pulse,
   input  logic              run_pulse,
   input  logic              brk_en,
   input  logic [BRK_W-1:0]  brk_addr,
   input  logic [1:0]        speed_sel,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              cpu_ce_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  step_cnt_o,
   output logic              brk_hit_o
);

   logic [1:0]       state;
   logic             ce;
   logic [CNT_W-1:0] cnt;
   logic             brk_hit;
   logic             skip;
   logic             tick;
   logic             brk_match;
   logic             unused_pc;

   run_tick_gen #(
      .RUN_DIV_W(RUN_DIV_W)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .clr       (state != ST_RUN),
      .speed_sel (speed_sel),
      .tick      (tick)
   );

   // Word-index compare; skip lets the first tick of a run leave the breakpoint PC.
   assign brk_match = brk_en && !skip && (pc_i[BRK_W+1:2] == brk_addr);
   assign unused_pc = ^{pc_i[ADDR_W-1:BRK_W+2], pc_i[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_HALT;
         ce      <= 1'b0;
         cnt     <= '0;
         brk_hit <= 1'b0;
         skip    <= 1'b0;
      end else begin
         ce <= 1'b0;
         if (ce) begin
            cnt <= cnt + 1'b1;
         end
         case (state)
            ST_HALT: begin
               if (run_pulse) begin
                  state <= ST_RUN;
                  skip  <= 1'b1;
               end else if (step_pulse) begin
                  state <= ST_STEP;
                  ce    <= 1'b1;
               end
            end
            ST_STEP: begin
               state <= ST_HALT;
            end
            ST_RUN: begin
               if (run_pulse) begin
                  state <= ST_HALT;
               end else if (tick) begin
                  if (brk_match) begin
                     state   <= ST_BRK;
                     brk_hit <= 1'b1;
                  end else begin
                     ce   <= 1'b1;
                     skip <= 1'b0;
                  end
               end
            end
            ST_BRK: begin
               if (run_pulse) begin
                  state   <= ST_RUN;
                  skip    <= 1'b1;
                  brk_hit <= 1'b0;
               end else if (step_pulse) begin
                  state   <= ST_STEP;
                  ce      <= 1'b1;
                  brk_hit <= 1'b0;
               end
            end
         endcase
      end
   end

   assign cpu_ce_o   = ce;
   assign state_o    = state;
   assign step_cnt_o = cnt;
   assign brk_hit_o  = brk_hit;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: step latency, run rate, breakpoint/skip,
// pulse priorities, counter wrap and asynchronous reset.
module tb_cpu_step_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        step_pulse;
   logic        run_pulse;
   logic        brk_en;
   logic [7:0]  brk_addr;
   logic [1:0]  speed_sel;
   logic [31:0] pc_i;
   logic        cpu_ce_o;
   logic [1:0]  state_o;
   logic [15:0] step_cnt_o;
   logic        brk_hit_o;

   logic        pc_load;
   int          n_checks = 0;
   int          n_fail   = 0;

   cpu_step_ctrl #(
      .ADDR_W    (32),
      .BRK_W     (8),
      .RUN_DIV_W (24),
      .CNT_W     (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .step_pulse (step_pulse),
      .run_pulse  (run_pulse),
      .brk_en     (brk_en),
      .brk_addr   (brk_addr),
      .speed_sel  (speed_sel),
      .pc_i       (pc_i),
      .cpu_ce_o   (cpu_ce_o),
      .state_o    (state_o),
      .step_cnt_o (step_cnt_o),
      .brk_hit_o  (brk_hit_o)
   );

   always #5 clk = ~clk;

   // CPU model: the PC moves on by one word during each enabled cycle.
   always @(negedge clk) begin
      if (pc_load) pc_i <= 32'd0;
      else if (cpu_ce_o) pc_i <= pc_i + 32'd4;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ce(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_ce_o && n < 2000);
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      pc_load    = 1'b1;
      step_pulse = 1'b0;
      run_pulse  = 1'b0;
      repeat (3) @(negedge clk);
      rst     = 1'b1;
      pc_load = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      int n_ce;
      int guard;

      rst        = 1'b0;
      pc_load    = 1'b1;
      step_pulse = 1'b0;
      run_pulse  = 1'b0;
      brk_en     = 1'b0;
      brk_addr   = 8'h00;
      speed_sel  = 2'b00;
      repeat (3) @(negedge clk);
      check_eq("rst_state", 32'(state_o), 32'd0);
      check_eq("rst_ce", 32'(cpu_ce_o), 32'd0);
      check_eq("rst_cnt", 32'(step_cnt_o), 32'd0);
      check_eq("rst_brk", 32'(brk_hit_o), 32'd0);
      rst     = 1'b1;
      pc_load = 1'b0;

      // Single step: enable for exactly the cycle after the pulse.
      repeat (7) @(negedge clk);
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      check_eq("step_ce", 32'(cpu_ce_o), 32'd1);
      check_eq("step_state", 32'(state_o), 32'd1);
      @(negedge clk);
      check_eq("step_ce_off", 32'(cpu_ce_o), 32'd0);
      check_eq("step_state_halt", 32'(state_o), 32'd0);
      check_eq("step_cnt", 32'(step_cnt_o), 32'd1);

      // Run at 2^8: enables every 256 cycles; halt coincident with a tick.
      do_reset();
      speed_sel = 2'b01;
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      check_eq("run_state", 32'(state_o), 32'd2);
      for (int p = 0; p < 4; p++) begin
         wait_ce(gap);
         check_eq("run_gap", 32'(gap), 32'd256);
      end
      @(negedge clk);
      check_eq("run_cnt4", 32'(step_cnt_o), 32'd4);
      repeat (254) @(negedge clk);
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      check_eq("halt_tick_ce", 32'(cpu_ce_o), 32'd0);
      check_eq("halt_tick_state", 32'(state_o), 32'd0);
      n_ce = 0;
      repeat (300) begin
         @(negedge clk);
         if (cpu_ce_o) n_ce++;
      end
      check_eq("halt_no_ce", 32'(n_ce), 32'd0);
      check_eq("halt_cnt", 32'(step_cnt_o), 32'd4);

      // Breakpoint at word 5 (pc 0x14) with an enable every cycle.
      do_reset();
      speed_sel = 2'b00;
      brk_en    = 1'b1;
      brk_addr  = 8'h05;
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      n_ce = 0;
      guard = 0;
      while (state_o != 2'd3 && guard < 50) begin
         @(negedge clk);
         guard++;
         if (cpu_ce_o) n_ce++;
      end
      check_eq("brk_state", 32'(state_o), 32'd3);
      check_eq("brk_enables", 32'(n_ce), 32'd5);
      check_eq("brk_ce", 32'(cpu_ce_o), 32'd0);
      check_eq("brk_hit", 32'(brk_hit_o), 32'd1);
      check_eq("brk_cnt", 32'(step_cnt_o), 32'd5);
      brk_en = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("brk_hold_state", 32'(state_o), 32'd3);
      check_eq("brk_hold_hit", 32'(brk_hit_o), 32'd1);
      brk_en = 1'b1;
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      check_eq("resume_state", 32'(state_o), 32'd2);
      check_eq("resume_hit", 32'(brk_hit_o), 32'd0);
      @(negedge clk);
      check_eq("resume_skip_ce", 32'(cpu_ce_o), 32'd1);
      repeat (3) @(negedge clk);
      check_eq("resume_running", 32'(state_o), 32'd2);
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      check_eq("resume_halt", 32'(state_o), 32'd0);

      // Both pulses from HALT: run wins; step ignored while running.
      do_reset();
      speed_sel  = 2'b01;
      brk_en     = 1'b0;
      step_pulse = 1'b1;
      run_pulse  = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      run_pulse  = 1'b0;
      check_eq("both_state", 32'(state_o), 32'd2);
      check_eq("both_ce", 32'(cpu_ce_o), 32'd0);
      @(negedge clk);
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      check_eq("runstep_state", 32'(state_o), 32'd2);
      repeat (3) @(negedge clk);
      check_eq("runstep_cnt", 32'(step_cnt_o), 32'd0);
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      check_eq("runstep_halt", 32'(state_o), 32'd0);

      // Counter wrap: run to 65535 enables, halt, then one more step.
      do_reset();
      speed_sel = 2'b00;
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      guard = 0;
      while (!(cpu_ce_o && step_cnt_o == 16'hFFFE) && guard < 70000) begin
         @(negedge clk);
         guard++;
      end
      check_eq("wrap_reached", 32'(guard < 70000), 32'd1);
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      check_eq("wrap_cnt_max", 32'(step_cnt_o), 32'h0000FFFF);
      check_eq("wrap_halt", 32'(state_o), 32'd0);
      step_pulse = 1'b1;
      @(negedge clk);
      step_pulse = 1'b0;
      check_eq("wrap_step_ce", 32'(cpu_ce_o), 32'd1);
      @(negedge clk);
      check_eq("wrap_cnt_zero", 32'(step_cnt_o), 32'd0);

      // Asynchronous reset in the middle of a run.
      run_pulse = 1'b1;
      @(negedge clk);
      run_pulse = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("arst_pre_ce", 32'(cpu_ce_o), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check_eq("arst_ce", 32'(cpu_ce_o), 32'd0);
      check_eq("arst_state", 32'(state_o), 32'd0);
      check_eq("arst_cnt", 32'(step_cnt_o), 32'd0);
      check_eq("arst_brk", 32'(brk_hit_o), 32'd0);
      n_ce = 0;
      repeat (5) begin
         @(negedge clk);
         if (cpu_ce_o) n_ce++;
      end
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (cpu_ce_o) n_ce++;
      end
      check_eq("arst_no_ce", 32'(n_ce), 32'd0);
      check_eq("arst_after_state", 32'(state_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Run/step/breakpoint sequencer for the OpenMIPS core on the board SOPC.
- Runs from the 100 MHz board clock and takes debounced one-cycle button pulses from the anti-jitter block.
- Issues a registered one-cycle clock-enable to the CPU: a single step, free-running at a switch-selected rate, or halted on a PC breakpoint.
- Exports state, step count and breakpoint status for the LED/7-seg display muxes.

Parameters:
ADDR_W, 32, width of pc_i (matches the instruction-address bus)
BRK_W, 8, breakpoint compare width; compares word index pc_i[BRK_W+1:2]
RUN_DIV_W, 24, run-rate divider width; must be ≥ 17
CNT_W, 16, width of the step counter

Ports:
clk  in  1  board clock, 100 MHz
rst  in  1  asynchronous reset, active-low
step_pulse  in  1  debounced single-step request, one cycle wide
run_pulse  in  1  debounced run/halt toggle, one cycle wide
brk_en  in  1  breakpoint enable (switch level)
brk_addr  in  BRK_W  breakpoint word index
speed_sel  in  2  run rate select
pc_i  in  ADDR_W  current CPU instruction address
cpu_ce_o  out  1  CPU clock-enable, one-cycle pulses
state_o  out  2  FSM state: HALT=0, STEP=1, RUN=2, BRK=3
step_cnt_o  out  CNT_W  number of enables issued
brk_hit_o  out  1  sticky breakpoint-hit flag

Behaviour:
Reset (rst=0, asynchronous):
- state=HALT, cpu_ce_o=0, step_cnt_o=0, brk_hit_o=0, divider=0, skip=0.
- Reset asserted mid-RUN or mid-STEP aborts immediately; no enable is emitted after the reset edge.

Outputs:
- All outputs registered; no combinational path from inputs to outputs.

Run-rate tick (internal, RUN only):
- Free divider counts up each clk while in RUN; it is cleared on every entry to RUN.
- Terminal count by speed_sel: 00 → every cycle; 01 → 2^8 cycles; 10 → 2^16 cycles; 11 → 2^RUN_DIV_W cycles.
- tick=1 on the terminal count; the divider then wraps to 0.

FSM:
- HALT: cpu_ce_o=0.
  - run_pulse → RUN, skip=1.
  - step_pulse alone → STEP.
  - Both in the same cycle: run_pulse wins.
- STEP: cpu_ce_o=1 for exactly this one cycle, then HALT unconditionally.
  - Latency: pulse sampled at edge n, cpu_ce_o high during cycle n+1, low at n+2.
  - Step pulses arriving during STEP are ignored.
- RUN:
  - On tick with no breakpoint: cpu_ce_o=1 for one cycle and skip clears.
  - Breakpoint: a tick where brk_en=1, skip=0 and pc_i[BRK_W+1:2]==brk_addr is suppressed (cpu_ce_o=0). Next state BRK, brk_hit_o←1.
  - run_pulse → HALT. It has priority over a same-cycle tick: the enable is suppressed.
  - step_pulse is ignored.
- BRK: cpu_ce_o=0, brk_hit_o=1.
  - step_pulse → STEP, brk_hit_o←0.
  - run_pulse → RUN, skip=1, brk_hit_o←0.
  - Both in the same cycle: run_pulse wins.
- skip: exempts the first tick after entering RUN from the breakpoint compare, so a run can leave the breakpoint PC.
- brk_en deasserted during BRK: remains in BRK until a pulse arrives.

Counter:
- step_cnt_o increments on every cycle cpu_ce_o=1.
- Wraps 2^CNT_W−1 → 0 with no flag.

Decomposition:
- Shared defines file: state encodings (HALT/STEP/RUN/BRK) and speed_sel codes.
- Sub-module run_tick_gen: divider plus terminal-count select.
  - Inputs: clk, rst, clr, speed_sel.
  - Output: tick.
- FSM, skip flag, breakpoint compare and counter stay in cpu_step_ctrl.

Test Plan:
- Reset then step_pulse at cycle 10 → cpu_ce_o=1 only in cycle 11, state_o 0→1→0, step_cnt_o=1.
- speed_sel=01, run_pulse → cpu_ce_o pulses every 256 cycles. After 4 pulses step_cnt_o=4; run_pulse coincident with a tick → no enable, state_o=0.
- speed_sel=00, brk_en=1, brk_addr=0x05; bench model advances pc_i by 4 per enable from 0 → 5 enables issued (pc 0x00–0x10). Enable at pc_i=0x14 suppressed, state_o=3, brk_hit_o=1, step_cnt_o=5.
- From that BRK, run_pulse → first tick issues an enable despite pc_i=0x14 (skip), brk_hit_o=0. Run continues until a later match or run_pulse.
- step_pulse and run_pulse in the same cycle from HALT → state_o=2, no STEP enable. step_pulse while in RUN → ignored.
- CNT_W=16, preload via 65535 steps then one more step → step_cnt_o=0. Assert rst mid-RUN → all outputs 0 asynchronously, no further cpu_ce_o.
